gf180mcu_ocd_io__pwr_seq: RTL and testbench

- Digital supply-sequencing controller for the pad ring.
- Watches the asynchronous DVDD-good and VDD-good detector levels of the IO ring.
- Debounces them, then releases core-to-pad isolation and enables pad drivers in a fixed order.
- On any supply dropout it forces the safe state at once, counts the dropout and latches a sticky fault.

---
 rtl/gf180mcu_ocd_io_pkg.sv | 18 +
 rtl/gf180mcu_ocd_io__sync2.sv | 27 ++
 rtl/gf180mcu_ocd_io__pwr_seq.sv | 135 +++++++++++++
 tb/tb_gf180mcu_ocd_io__pwr_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_ocd_io_pkg.sv
// Shared types and constants for the IO-ring supply sequencer.
`default_nettype none

package gf180mcu_ocd_io_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_ON       = 2'd3
  } pwr_state_t;

  localparam int                DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

endpackage

`default_nettype wire

// File: rtl/gf180mcu_ocd_io__sync2.sv
// Two-flop synchroniser for a single asynchronous level, with selectable reset value.
`default_nettype none

module gf180mcu_ocd_io__sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gf180mcu_ocd_io__pwr_seq.sv
// Pad-ring supply sequencer: debounces supply-good levels, releases isolation,
// then enables pads; any dropout forces the safe state and records a sticky fault.
`default_nettype none

module gf180mcu_ocd_io__pwr_seq
  import gf180mcu_ocd_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int ISO_DELAY       = 16,
  parameter int CNT_W           = 12
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              DVDD_OK,
  input  logic              VDD_OK,
  input  logic              CLR_FAULT,
  output logic              ISO_N,
  output logic              PAD_EN,
  output logic              PWR_GOOD,
  output logic              FAULT,
  output logic [DROP_W-1:0] DROP_CNT,
  output logic [1:0]        STATE
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DELAY - 1);

  logic dvdd_sync;
  logic vdd_sync;
  logic ok;

  gf180mcu_ocd_io__sync2 #(.RESET_VAL(1'b0)) u_sync_dvdd (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (DVDD_OK),
    .q     (dvdd_sync)
  );

  gf180mcu_ocd_io__sync2 #(.RESET_VAL(1'b0)) u_sync_vdd (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (VDD_OK),
    .q     (vdd_sync)
  );

  assign ok = dvdd_sync & vdd_sync;

  pwr_state_t        state;
  pwr_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              dropout;
  logic              fault_nxt;
  logic [DROP_W-1:0] drop_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dropout   = 1'b0;
    case (state)
      ST_OFF: begin
        cnt_nxt = '0;
        if (ok) state_nxt = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!ok) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ok) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else if (cnt == ISO_LAST) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_ON: begin
        cnt_nxt = '0;
        if (!ok) begin
          state_nxt = ST_OFF;
          dropout   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Clear is applied first so a coincident dropout still counts as the first event.
  always_comb begin
    fault_nxt = CLR_FAULT ? 1'b0 : FAULT;
    drop_nxt  = CLR_FAULT ? '0 : DROP_CNT;
    if (dropout) begin
      fault_nxt = 1'b1;
      if (drop_nxt != DROP_MAX) drop_nxt = drop_nxt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state    <= ST_OFF;
      cnt      <= '0;
      ISO_N    <= 1'b0;
      PAD_EN   <= 1'b0;
      PWR_GOOD <= 1'b0;
      FAULT    <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ISO_N    <= (state_nxt == ST_RELEASE) || (state_nxt == ST_ON);
      PAD_EN   <= (state_nxt == ST_ON);
      PWR_GOOD <= (state_nxt == ST_ON);
      FAULT    <= fault_nxt;
      DROP_CNT <= drop_nxt;
    end
  end

  assign STATE = state;

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_ocd_io__pwr_seq.sv
// Self-checking bench for the supply sequencer (DEBOUNCE_CYCLES=8, ISO_DELAY=4).
`timescale 1ns/1ps
`default_nettype none

module tb_gf180mcu_ocd_io__pwr_seq;

  localparam int DB  = 8;
  localparam int ISO = 4;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       DVDD_OK = 1'b0;
  logic       VDD_OK = 1'b0;
  logic       CLR_FAULT = 1'b0;
  logic       ISO_N;
  logic       PAD_EN;
  logic       PWR_GOOD;
  logic       FAULT;
  logic [7:0] DROP_CNT;
  logic [1:0] STATE;

  gf180mcu_ocd_io__pwr_seq #(
    .DEBOUNCE_CYCLES (DB),
    .ISO_DELAY       (ISO),
    .CNT_W           (4)
  ) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .DVDD_OK   (DVDD_OK),
    .VDD_OK    (VDD_OK),
    .CLR_FAULT (CLR_FAULT),
    .ISO_N     (ISO_N),
    .PAD_EN    (PAD_EN),
    .PWR_GOOD  (PWR_GOOD),
    .FAULT     (FAULT),
    .DROP_CNT  (DROP_CNT),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the sequence is a function of how many consecutive edges
  // have seen a (two-edge delayed) good supply.
  int run = 0;
  bit h1 = 0, h2 = 0;
  bit m_fault = 0;
  int m_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_state(input int r);
    if (r == 0) return 0;
    if (r <= DB) return 1;
    if (r <= DB + ISO) return 2;
    return 3;
  endfunction

  task automatic model_step();
    bit okv, was_on;
    if (!RESETN) begin
      run = 0; h1 = 0; h2 = 0; m_fault = 0; m_drop = 0;
    end else begin
      okv    = h2;
      h2     = h1;
      h1     = DVDD_OK & VDD_OK;
      was_on = (run >= DB + 1 + ISO);
      run    = okv ? ((run < 10000) ? run + 1 : run) : 0;
      if (CLR_FAULT) begin m_fault = 0; m_drop = 0; end
      if (was_on && !okv) begin
        m_fault = 1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    chk("mdl_iso_n",   ISO_N,    (run >= DB + 1) ? 1 : 0);
    chk("mdl_pad_en",  PAD_EN,   (run >= DB + 1 + ISO) ? 1 : 0);
    chk("mdl_pwr_good",PWR_GOOD, (run >= DB + 1 + ISO) ? 1 : 0);
    chk("mdl_state",   STATE,    exp_state(run));
    chk("mdl_fault",   FAULT,    m_fault);
    chk("mdl_drop_cnt",DROP_CNT, m_drop);
    chk("iso_covers_pad", (PAD_EN && !ISO_N) ? 1 : 0, 0);
  endtask

  task automatic drive(input bit r, input bit d, input bit v, input bit c, input int n);
    @(negedge CLK);
    RESETN = r; DVDD_OK = d; VDD_OK = v; CLR_FAULT = c;
    repeat (n) cycle();
  endtask

  typedef struct {
    bit rstn; bit dvdd; bit vdd; bit clr; int n;
    bit iso; bit pad; int st; bit flt; int dc;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  initial begin
    // reset
    tbl[0]  = '{0,0,0,0, 2, 0,0,0,0,0};
    // power-up from edge 0: ISO_N after edge 10, PAD_EN after edge 14
    tbl[1]  = '{1,1,1,0,10, 0,0,1,0,0};
    tbl[2]  = '{1,1,1,0, 1, 1,0,2,0,0};
    tbl[3]  = '{1,1,1,0, 3, 1,0,2,0,0};
    tbl[4]  = '{1,1,1,0, 1, 1,1,3,0,0};
    // DVDD dropout: still on after edge m+1, off after m+2
    tbl[5]  = '{1,0,1,0, 2, 1,1,3,0,0};
    tbl[6]  = '{1,0,1,0, 1, 0,0,0,1,1};
    // lone clear, then coincident clear + dropout
    tbl[7]  = '{1,0,1,1, 1, 0,0,0,0,0};
    tbl[8]  = '{1,1,1,0,15, 1,1,3,0,0};
    tbl[9]  = '{1,1,0,0, 2, 1,1,3,0,0};
    tbl[10] = '{1,1,0,1, 1, 0,0,0,1,1};
    tbl[11] = '{1,1,0,1, 1, 0,0,0,0,0};
    // one-cycle VDD glitch at debounce count 5 restarts the window
    tbl[12] = '{1,1,1,0, 7, 0,0,1,0,0};
    tbl[13] = '{1,1,0,0, 1, 0,0,1,0,0};
    tbl[14] = '{1,1,1,0, 1, 0,0,1,0,0};
    tbl[15] = '{1,1,1,0, 1, 0,0,0,0,0};
    tbl[16] = '{1,1,1,0, 8, 0,0,1,0,0};
    tbl[17] = '{1,1,1,0, 1, 1,0,2,0,0};
    // reset pulse in RELEASE, then resequence with scenario-1 timing
    tbl[18] = '{0,1,1,0, 1, 0,0,0,0,0};
    tbl[19] = '{1,1,1,0,10, 0,0,1,0,0};
    tbl[20] = '{1,1,1,0, 1, 1,0,2,0,0};
    tbl[21] = '{1,1,1,0, 3, 1,0,2,0,0};
    tbl[22] = '{1,1,1,0, 1, 1,1,3,0,0};
    // CLR_FAULT does not disturb ON
    tbl[23] = '{1,1,1,1, 3, 1,1,3,0,0};
    // dropout from RELEASE is not a fault
    tbl[24] = '{1,0,0,0, 2, 1,1,3,0,0};
    tbl[25] = '{1,0,0,0, 1, 0,0,0,1,1};
    tbl[26] = '{1,1,1,0,11, 1,0,2,1,1};
    tbl[27] = '{1,1,0,0, 3, 0,0,0,1,1};
    tbl[28] = '{1,1,0,0, 1, 0,0,0,1,1};
  end

  initial begin
    #1;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rstn, tbl[i].dvdd, tbl[i].vdd, tbl[i].clr, tbl[i].n);
      chk($sformatf("tbl%0d_iso_n", i),    ISO_N,    tbl[i].iso);
      chk($sformatf("tbl%0d_pad_en", i),   PAD_EN,   tbl[i].pad);
      chk($sformatf("tbl%0d_pwr_good", i), PWR_GOOD, tbl[i].pad);
      chk($sformatf("tbl%0d_state", i),    STATE,    tbl[i].st);
      chk($sformatf("tbl%0d_fault", i),    FAULT,    tbl[i].flt);
      chk($sformatf("tbl%0d_drop_cnt", i), DROP_CNT, tbl[i].dc);
    end

    // 260 more power-up/dropout cycles: counter must stick at 255
    for (int i = 0; i < 260; i++) begin
      drive(1, 1, 1, 0, 15);
      drive(1, 0, 1, 0, 3);
    end
    chk("sat_drop_cnt", DROP_CNT, 255);
    chk("sat_fault",    FAULT,    1);
    drive(1, 0, 1, 0, 5);
    chk("sat_hold",     DROP_CNT, 255);
    drive(1, 0, 1, 1, 1);
    chk("sat_clear",    DROP_CNT, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 29) != 0),
            ($urandom_range(0, 29) != 0),
            ($urandom_range(0, 15) == 0), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
